// File: rtl/memfifo_chk_pkg.sv
// Constants and types shared by the memfifo test-data generator and the receive-side checker.
package memfifo_test_pkg;

  localparam logic [13:0] CS_INIT     = 14'd47;
  localparam logic [6:0]  CNT_INC     = 7'd111;
  localparam int unsigned FRAME_WORDS = 8;
  localparam int unsigned SYNC_POS    = 14;
  localparam int unsigned WPOS_W      = $clog2(FRAME_WORDS);

  typedef enum logic {HUNT, LOCKED} chk_state_e;

  // First-error record: byte index in frame, expected byte, received byte.
  typedef struct packed {
    logic [3:0] pos;
    logic [7:0] exp;
    logic [7:0] got;
  } err_rec_t;

  // Sync bit carried by byte i of a frame.
  function automatic logic sync_bit(input logic [3:0] i);
    return i[0] || (i == 4'(SYNC_POS));
  endfunction

  function automatic logic [6:0] cs_fold(input logic [13:0] s);
    return s[6:0] ^ s[13:7];
  endfunction

endpackage

// File: rtl/memfifo_chk_word.sv
// Combinational check of one 16-bit word at frame word position k.
// With MEMFIFO_CHK_ERRLOG_EN defined it also reports the first offending byte.
module memfifo_chk_word
  import memfifo_test_pkg::*;
(
  input  logic [15:0]       di,
  input  logic [WPOS_W-1:0] k,
  input  logic [6:0]        exp,
  input  logic              seeded,
  input  logic [13:0]       cs,
  output logic              sync_bad,
  output logic              cnt_bad,
  output logic              cs_bad,
  output logic [6:0]        exp_next,
  output logic [13:0]       cs_next
`ifdef MEMFIFO_CHK_ERRLOG_EN
  ,
  output err_rec_t          err
`endif
);

  localparam logic [6:0] WORD_INC = CNT_INC + CNT_INC;

  logic [7:0]  lo, hi;
  logic [3:0]  lo_idx, hi_idx;
  logic        last;
  logic        lo_sync_bad, hi_sync_bad;
  logic [6:0]  exp_lo, exp_hi;
  logic        lo_cnt_bad, hi_cnt_bad;
  logic [6:0]  cs_exp;

  assign lo     = di[7:0];
  assign hi     = di[15:8];
  assign lo_idx = {k, 1'b0};
  assign hi_idx = {k, 1'b1};
  assign last   = (k == WPOS_W'(FRAME_WORDS - 1));

  assign lo_sync_bad = lo[7] != sync_bit(lo_idx);
  assign hi_sync_bad = hi[7] != sync_bit(hi_idx);
  assign sync_bad    = lo_sync_bad || hi_sync_bad;

  // First word after lock seeds the counter expectation from the stream itself.
  assign exp_lo     = seeded ? exp : lo[6:0];
  assign exp_hi     = exp_lo + CNT_INC;
  assign lo_cnt_bad = lo[6:0] != exp_lo;
  assign hi_cnt_bad = !last && (hi[6:0] != exp_hi);
  assign cnt_bad    = lo_cnt_bad || hi_cnt_bad;
  assign exp_next   = lo[6:0] + (last ? CNT_INC : WORD_INC);

  assign cs_next = cs + 14'(lo) + (last ? 14'd0 : 14'(hi));
  assign cs_exp  = cs_fold(cs_next);
  assign cs_bad  = last && (hi[6:0] != cs_exp);

`ifdef MEMFIFO_CHK_ERRLOG_EN
  always_comb begin
    err = '{pos: lo_idx, exp: {sync_bit(lo_idx), lo[6:0]}, got: lo};
    if (lo_sync_bad) begin
      err = '{pos: lo_idx, exp: {sync_bit(lo_idx), lo[6:0]}, got: lo};
    end else if (hi_sync_bad) begin
      err = '{pos: hi_idx, exp: {sync_bit(hi_idx), hi[6:0]}, got: hi};
    end else if (lo_cnt_bad) begin
      err = '{pos: lo_idx, exp: {lo[7], exp_lo}, got: lo};
    end else if (hi_cnt_bad) begin
      err = '{pos: hi_idx, exp: {hi[7], exp_hi}, got: hi};
    end else begin
      err = '{pos: hi_idx, exp: {hi[7], cs_exp}, got: hi};
    end
  end
`endif

endmodule

// File: rtl/memfifo_chk.sv
// Receive-side checker for the memfifo test stream: frame lock, counter/checksum checks, statistics.
// Optional first-error capture ports are enabled by defining MEMFIFO_CHK_ERRLOG_EN.
module memfifo_chk
  import memfifo_test_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned ERR_W = 16
) (
  input  logic             ifclk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [15:0]      DI,
  input  logic             DI_valid,
  output logic             DI_ready,
  output logic             locked,
  output logic [CNT_W-1:0] frames_ok,
  output logic [ERR_W-1:0] cnt_err,
  output logic [ERR_W-1:0] cs_err,
  output logic [ERR_W-1:0] sync_err,
  output logic             err_sticky
`ifdef MEMFIFO_CHK_ERRLOG_EN
  ,
  output logic [3:0]       err_pos,
  output logic [7:0]       err_exp,
  output logic [7:0]       err_got
`endif
);

  chk_state_e        state;
  logic [WPOS_W-1:0] wpos;
  logic [6:0]        exp;
  logic              seeded;
  logic [13:0]       cs;
  logic              frame_bad;

  logic        sync_bad, cnt_bad, cs_bad;
  logic [6:0]  exp_next;
  logic [13:0] cs_next;
  logic        acc, chk, last;
  logic        sync_hit, cnt_hit, cs_hit, frame_good;

`ifdef MEMFIFO_CHK_ERRLOG_EN
  err_rec_t err_now, err_log;
  logic     err_logged;
`endif

  memfifo_chk_word u_word (
    .di       (DI),
    .k        (wpos),
    .exp      (exp),
    .seeded   (seeded),
    .cs       (cs),
    .sync_bad (sync_bad),
    .cnt_bad  (cnt_bad),
    .cs_bad   (cs_bad),
    .exp_next (exp_next),
    .cs_next  (cs_next)
`ifdef MEMFIFO_CHK_ERRLOG_EN
    ,
    .err      (err_now)
`endif
  );

  // A sync failure aborts the word; no other check is scored.
  assign acc        = DI_valid && DI_ready && enable;
  assign chk        = acc && (state == LOCKED);
  assign last       = (wpos == WPOS_W'(FRAME_WORDS - 1));
  assign sync_hit   = chk && sync_bad;
  assign cnt_hit    = chk && !sync_bad && cnt_bad;
  assign cs_hit     = chk && !sync_bad && cs_bad;
  assign frame_good = chk && !sync_bad && last && !frame_bad && !cnt_bad && !cs_bad;

  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      locked     <= 1'b0;
      DI_ready   <= 1'b0;
      wpos       <= '0;
      exp        <= '0;
      seeded     <= 1'b0;
      cs         <= CS_INIT;
      frame_bad  <= 1'b0;
      frames_ok  <= '0;
      cnt_err    <= '0;
      cs_err     <= '0;
      sync_err   <= '0;
      err_sticky <= 1'b0;
    end else begin
      DI_ready <= 1'b1;
      if (acc) begin
        case (state)
          HUNT: begin
            if (DI[7] && DI[15]) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              wpos      <= '0;
              cs        <= CS_INIT;
              seeded    <= 1'b0;
              frame_bad <= 1'b0;
            end
          end
          LOCKED: begin
            if (sync_bad) begin
              state  <= HUNT;
              locked <= 1'b0;
            end else begin
              seeded <= 1'b1;
              exp    <= exp_next;
              if (last) begin
                wpos      <= '0;
                cs        <= CS_INIT;
                frame_bad <= 1'b0;
              end else begin
                wpos      <= wpos + WPOS_W'(1);
                cs        <= cs_next;
                frame_bad <= frame_bad || cnt_bad;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end

      // Saturating statistics; clear takes priority over a same-cycle increment.
      if (clear) begin
        frames_ok <= '0;
        cnt_err   <= '0;
        cs_err    <= '0;
        sync_err  <= '0;
      end else begin
        if (frame_good && (frames_ok != '1)) frames_ok <= frames_ok + CNT_W'(1);
        if (cnt_hit && (cnt_err != '1))      cnt_err   <= cnt_err + ERR_W'(1);
        if (cs_hit && (cs_err != '1))        cs_err    <= cs_err + ERR_W'(1);
        if (sync_hit && (sync_err != '1))    sync_err  <= sync_err + ERR_W'(1);
      end

      if (sync_hit || cnt_hit || cs_hit) err_sticky <= 1'b1;
      else if (clear)                    err_sticky <= 1'b0;
    end
  end

`ifdef MEMFIFO_CHK_ERRLOG_EN
  // Holds the first error seen since reset or clear.
  always_ff @(posedge ifclk or negedge reset_n) begin
    if (!reset_n) begin
      err_log    <= '0;
      err_logged <= 1'b0;
    end else begin
      if (clear) begin
        err_log    <= '0;
        err_logged <= 1'b0;
      end
      if ((sync_hit || cnt_hit || cs_hit) && (clear || !err_logged)) begin
        err_log    <= err_now;
        err_logged <= 1'b1;
      end
    end
  end

  assign err_pos = err_log.pos;
  assign err_exp = err_log.exp;
  assign err_got = err_log.got;
`endif

endmodule

// File: tb/tb_memfifo_chk.sv
// Scoreboard bench for memfifo_chk: stimulus pushes expected status per word, a monitor pops and compares.
// Also covers the MEMFIFO_CHK_ERRLOG_EN ports when that macro is defined.
module tb_memfifo_chk;

  typedef struct packed {
    logic        locked;
    logic [31:0] fo;
    logic [15:0] ce;
    logic [15:0] cs;
    logic [15:0] se;
    logic        sticky;
  } stat_t;

  typedef struct {
    bit    chk;
    stat_t exp;
    string nm;
  } sb_t;

  logic        ifclk = 1'b0;
  logic        reset_n, enable, clear, DI_valid;
  logic [15:0] DI;
  logic        DI_ready, locked, err_sticky;
  logic [31:0] frames_ok;
  logic [15:0] cnt_err, cs_err, sync_err;
`ifdef MEMFIFO_CHK_ERRLOG_EN
  logic [3:0]  err_pos;
  logic [7:0]  err_exp, err_got;
`endif

  int    n_chk = 0;
  int    n_pass = 0;
  sb_t   sbq[$];
  stat_t ex;
  logic [6:0]  gen_c;
  logic [15:0] fw [8];
  logic [15:0] f1 [8] = '{16'hEF00, 16'hCD5E, 16'hAB3C, 16'h891A,
                          16'hE778, 16'hC556, 16'hA334, 16'hB992};

  memfifo_chk #(.CNT_W(32), .ERR_W(16)) dut (
    .ifclk      (ifclk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .DI         (DI),
    .DI_valid   (DI_valid),
    .DI_ready   (DI_ready),
    .locked     (locked),
    .frames_ok  (frames_ok),
    .cnt_err    (cnt_err),
    .cs_err     (cs_err),
    .sync_err   (sync_err),
    .err_sticky (err_sticky)
`ifdef MEMFIFO_CHK_ERRLOG_EN
    ,
    .err_pos    (err_pos),
    .err_exp    (err_exp),
    .err_got    (err_got)
`endif
  );

  always #5 ifclk = ~ifclk;

  task automatic chk_stat(input string nm, input stat_t e);
    stat_t a;
    a = {locked, frames_ok, cnt_err, cs_err, sync_err, err_sticky};
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got lk=%0b fo=%0d ce=%0d cs=%0d se=%0d st=%0b want lk=%0b fo=%0d ce=%0d cs=%0d se=%0d st=%0b",
                  nm, a.locked, a.fo, a.ce, a.cs, a.se, a.sticky,
                  e.locked, e.fo, e.ce, e.cs, e.se, e.sticky);
  endtask

  task automatic chk_val(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
  endtask

  // Generator model: frame bytes from the running counter gen_c.
  task automatic make_frame(output logic [15:0] w [8]);
    logic [7:0]  b [16];
    logic [13:0] s;
    s = 14'd47;
    for (int i = 0; i < 15; i++) begin
      b[i]  = {(i[0] || i == 14), gen_c};
      gen_c = gen_c + 7'd111;
      s     = s + 14'(b[i]);
    end
    b[15] = {1'b1, s[6:0] ^ s[13:7]};
    for (int j = 0; j < 8; j++) w[j] = {b[2*j+1], b[2*j]};
  endtask

  task automatic send_word(input logic [15:0] w, input bit chk, input string nm);
    sb_t e;
    e.chk = chk;
    e.exp = ex;
    e.nm  = nm;
    sbq.push_back(e);
    DI       = w;
    DI_valid = 1'b1;
    @(posedge ifclk);
    #1;
    DI_valid = 1'b0;
  endtask

  task automatic send_good_frame(input string nm);
    make_frame(fw);
    for (int j = 0; j < 7; j++) send_word(fw[j], 1'b1, nm);
    ex.fo = ex.fo + 32'd1;
    send_word(fw[7], 1'b1, nm);
  endtask

  // Monitor: one status comparison per accepted word, sampled mid-cycle.
  initial begin : monitor
    bit  acc;
    sb_t e;
    forever begin
      @(posedge ifclk);
      acc = DI_valid && DI_ready;
      @(negedge ifclk);
      if (acc) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got accepted word, want none pending");
        end else begin
          e = sbq.pop_front();
          if (e.chk) chk_stat(e.nm, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; DI_valid = 1'b0; DI = '0;
    ex = '0;
    repeat (3) @(posedge ifclk);
    @(negedge ifclk);
    chk_val("rst_ready", 32'(DI_ready), 32'd0);
    chk_stat("rst_stat", ex);
    reset_n = 1'b1;
    #1 chk_val("ready_pre_edge", 32'(DI_ready), 32'd0);
    @(posedge ifclk); #1;
    chk_val("ready_post_edge", 32'(DI_ready), 32'd1);

    // Hunt through frame 1, locking on its last word.
    for (int j = 0; j < 7; j++) send_word(f1[j], 1'b1, "hunt");
    ex.locked = 1'b1;
    send_word(f1[7], 1'b1, "lock");
    gen_c = 7'd1;
    send_good_frame("frame2");
    send_good_frame("frame3");

    // Counter corruption in byte 4; the reseed also flags the following word.
    make_frame(fw);
    fw[2] = fw[2] ^ 16'h0001;
    send_word(fw[0], 1'b1, "cnt_pre");
    send_word(fw[1], 1'b1, "cnt_pre");
    ex.ce = 16'd1; ex.sticky = 1'b1;
    send_word(fw[2], 1'b1, "cnt_err_first");
    ex.ce = 16'd2;
    for (int j = 3; j < 7; j++) send_word(fw[j], 1'b1, "cnt_reseed");
    ex.cs = 16'd1;
    send_word(fw[7], 1'b1, "cnt_frame_end");
    send_good_frame("after_cnt_err");

    // Words while disabled are ignored entirely.
    enable = 1'b0;
    send_word(16'h0000, 1'b1, "enable_hold");
    send_word(16'h1234, 1'b1, "enable_hold");
    send_word(16'h8080, 1'b1, "enable_hold");
    enable = 1'b1;

    clear = 1'b1;
    @(posedge ifclk); #1;
    clear = 1'b0;
    ex = '0; ex.locked = 1'b1;
    chk_stat("clear", ex);

    // Checksum corruption in byte 15.
    make_frame(fw);
    fw[7] = fw[7] ^ 16'h0100;
    for (int j = 0; j < 7; j++) send_word(fw[j], 1'b1, "cs_pre");
    ex.cs = 16'd1; ex.sticky = 1'b1;
    send_word(fw[7], 1'b1, "cs_err");
    send_good_frame("after_cs_err");

    // Sync bit of byte 13 cleared: drop lock, relock on word 7 of the same frame.
    make_frame(fw);
    fw[6] = fw[6] & 16'h7FFF;
    for (int j = 0; j < 6; j++) send_word(fw[j], 1'b1, "sync_pre");
    ex.se = 16'd1; ex.locked = 1'b0;
    send_word(fw[6], 1'b1, "sync_err");
    ex.locked = 1'b1;
    send_word(fw[7], 1'b1, "relock");
    send_good_frame("resume");

    // Reset in the middle of a frame with DI_valid toggling.
    make_frame(fw);
    for (int j = 0; j < 3; j++) send_word(fw[j], 1'b1, "pre_reset");
    @(negedge ifclk); #1;
    reset_n = 1'b0;
    ex = '0;
    #1;
    chk_val("rst_mid_ready", 32'(DI_ready), 32'd0);
    chk_stat("rst_mid", ex);
    for (int i = 0; i < 4; i++) begin
      DI_valid = ~DI_valid;
      DI = fw[3];
      @(posedge ifclk); #1;
    end
    reset_n = 1'b1; DI_valid = 1'b0;
    #1 chk_val("rel_ready0", 32'(DI_ready), 32'd0);
    @(posedge ifclk); #1;
    chk_val("rel_ready1", 32'(DI_ready), 32'd1);
    repeat (4) @(posedge ifclk);
    #1 chk_stat("post_reset", ex);

    // Lock again, then one counter error per word until saturation.
    for (int j = 0; j < 7; j++) send_word(f1[j], 1'b1, "hunt2");
    ex.locked = 1'b1;
    send_word(f1[7], 1'b1, "lock2");
    ex.sticky = 1'b1;
    for (int n = 1; n <= 65544; n++) begin
      int k;
      k = (n - 1) % 8;
      ex.ce = (n > 65535) ? 16'hFFFF : 16'(n);
      ex.cs = 16'(n / 8);
      send_word((k == 7) ? 16'h8080 : 16'h8000,
                (n <= 3 || n == 65534 || n == 65535 || n == 65544), "cnt_sat");
    end

    // Clear coinciding with an error: counters clear, sticky still sets.
    clear = 1'b1;
    ex.ce = '0; ex.cs = '0;
    send_word(16'h8000, 1'b1, "clear_vs_err");
    clear = 1'b0;
    ex.ce = 16'd1;
    send_word(16'h8000, 1'b1, "cnt_after_clear");
    @(negedge ifclk);
`ifdef MEMFIFO_CHK_ERRLOG_EN
    chk_val("err_pos", 32'(err_pos), 32'd0);
    chk_val("err_exp", 32'(err_exp), 32'h6F);
    chk_val("err_got", 32'(err_got), 32'h00);
`endif

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge ifclk);
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
